pixel_fb_scanout: RTL and testbench

//   Sink side of the pixel-plot interface (x, y, colour, plot) driven by the game datapath.

---
 rtl/pixel_fb_scanout_if.sv | 21 ++
 rtl/pixel_fb_scanout.sv | 180 ++++++++++++++++++
 tb/tb_pixel_fb_scanout.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fb_scanout_if.sv
// Pixel-plot bus between the game datapath (master) and the frame-buffer scanout (slave).
// Carries single-pixel writes plus the bulk clear handshake and the frame marker.
interface pixel_fb_scanout_if;
   logic       plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       clear_req;
   logic       clear_busy;
   logic       frame_start;

   modport master (
      output plot, x, y, colour, clear_req,
      input  clear_busy, frame_start
   );

   modport slave (
      input  plot, x, y, colour, clear_req,
      output clear_busy, frame_start
   );
endinterface

// File: rtl/pixel_fb_scanout.sv
// 160x120x3 frame buffer fed by the pixel-plot bus, scanned out as 640x480@60 VGA with 4x4
// pixel replication, plus a clear-to-black sweep that owns the write port while it runs.
module pixel_fb_scanout #(
   parameter int unsigned H_VIS  = 640,
   parameter int unsigned H_FP   = 16,
   parameter int unsigned H_SYNC = 96,
   parameter int unsigned H_BP   = 48,
   parameter int unsigned V_VIS  = 480,
   parameter int unsigned V_FP   = 10,
   parameter int unsigned V_SYNC = 2,
   parameter int unsigned V_BP   = 33
) (
   input  logic              clk,
   input  logic              resetn,
   pixel_fb_scanout_if.slave bus,
   output logic              vga_clk_o,
   output logic              vga_hs_o,
   output logic              vga_vs_o,
   output logic              vga_blank_n_o,
   output logic              vga_sync_n_o,
   output logic              vga_r_o,
   output logic              vga_g_o,
   output logic              vga_b_o
);

   localparam int unsigned FB_W     = 160;
   localparam int unsigned FB_H     = 120;
   localparam int unsigned COL_W    = 3;
   localparam int unsigned SCALE_SH = 2;
   localparam int unsigned FB_DEPTH = FB_W * FB_H;

   localparam logic [9:0]  HLast   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  HVisEnd = 10'(H_VIS);
   localparam logic [9:0]  HsFirst = 10'(H_VIS + H_FP);
   localparam logic [9:0]  HsLast  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0]  VLast   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  VVisEnd = 10'(V_VIS);
   localparam logic [9:0]  VsFirst = 10'(V_VIS + V_FP);
   localparam logic [9:0]  VsLast  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [14:0] ClrLast = 15'(FB_DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StSweep, StDone} clr_state_e;

   // Scan timing
   logic       pix_en_q;
   logic [9:0] h_q, h_d, v_q, v_d;

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_en_q) begin
         if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pix_en_q <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
      end else begin
         pix_en_q <= ~pix_en_q;
         h_q      <= h_d;
         v_q      <= v_d;
      end
   end

   logic hs_raw, vs_raw, vis;
   assign hs_raw = !((h_q >= HsFirst) && (h_q <= HsLast));
   assign vs_raw = !((v_q >= VsFirst) && (v_q <= VsLast));
   assign vis    = (h_q < HVisEnd) && (v_q < VVisEnd);

   // y*160 as (y<<7)+(y<<5) on both ports
   logic [7:0]  vy, hx;
   logic [14:0] rd_addr, pl_addr;
   assign vy      = 8'(v_q >> SCALE_SH);
   assign hx      = 8'(h_q >> SCALE_SH);
   assign rd_addr = (15'(vy) << 7) + (15'(vy) << 5) + 15'(hx);
   assign pl_addr = (15'(bus.y) << 7) + (15'(bus.y) << 5) + 15'(bus.x);

   // Clear sweep
   clr_state_e       clr_state_q, clr_state_d;
   logic [14:0]      clr_addr_q, clr_addr_d;
   logic             clear_busy, pl_ok, wr_en;
   logic [14:0]      wr_addr;
   logic [COL_W-1:0] wr_data;

   assign clear_busy = (clr_state_q == StSweep);
   assign pl_ok      = bus.plot && !clear_busy && (bus.x < 8'(FB_W)) && (bus.y < 7'(FB_H));

   always_comb begin
      clr_state_d = clr_state_q;
      clr_addr_d  = clr_addr_q;
      wr_en       = pl_ok;
      wr_addr     = pl_addr;
      wr_data     = bus.colour;
      unique case (clr_state_q)
         StIdle: begin
            if (bus.clear_req) begin
               clr_state_d = StSweep;
               clr_addr_d  = '0;
            end
         end
         StSweep: begin
            wr_en      = 1'b1;
            wr_addr    = clr_addr_q;
            wr_data    = '0;
            clr_addr_d = clr_addr_q + 15'd1;
            if (clr_addr_q == ClrLast) clr_state_d = StDone;
         end
         StDone:  clr_state_d = StIdle;
         default: clr_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         clr_state_q <= StIdle;
         clr_addr_q  <= '0;
      end else begin
         clr_state_q <= clr_state_d;
         clr_addr_q  <= clr_addr_d;
      end
   end

   // Frame buffer: write-first ordering is not wanted, so the read sees the pre-write value
   logic [COL_W-1:0] mem_q [FB_DEPTH];
   logic [COL_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (pix_en_q && vis) rd_data_q <= mem_q[rd_addr];
   end

   // Two pixel-clock stages so sync/blank line up with the registered read data
   logic             hs_d1_q, vs_d1_q, vis_d1_q;
   logic             hs_q, vs_q, blank_n_q;
   logic [COL_W-1:0] rgb_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         hs_d1_q   <= 1'b1;
         vs_d1_q   <= 1'b1;
         vis_d1_q  <= 1'b0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         rgb_q     <= '0;
      end else if (pix_en_q) begin
         hs_d1_q   <= hs_raw;
         vs_d1_q   <= vs_raw;
         vis_d1_q  <= vis;
         hs_q      <= hs_d1_q;
         vs_q      <= vs_d1_q;
         blank_n_q <= vis_d1_q;
         rgb_q     <= vis_d1_q ? rd_data_q : '0;
      end
   end

   assign bus.clear_busy  = clear_busy;
   assign bus.frame_start = pix_en_q && (h_q == '0) && (v_q == '0);

   assign vga_clk_o     = pix_en_q;
   assign vga_hs_o      = hs_q;
   assign vga_vs_o      = vs_q;
   assign vga_blank_n_o = blank_n_q;
   assign vga_sync_n_o  = 1'b0;
   assign vga_r_o       = rgb_q[2];
   assign vga_g_o       = rgb_q[1];
   assign vga_b_o       = rgb_q[0];

endmodule

// File: tb/tb_pixel_fb_scanout.sv
// Directed bench: a shrunken-timing instance for frame-level pixel checks and a full-timing
// instance for the real 640x480 horizontal sync figures.
module tb_pixel_fb_scanout;

   localparam int HV = 32, HF = 2, HS = 4, HB = 2;
   localparam int VV = 8,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HV + HF + HS + HB;      // 40 pixels per line
   localparam int VT = VV + VF + VS + VB;      // 12 lines per frame
   localparam int FRAME_CLK = 2 * HT * VT;     // 960 clk
   localparam int VCOLS = HV / 4, VROWS = VV / 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   pixel_fb_scanout_if bus ();
   pixel_fb_scanout_if bus_full ();

   logic vga_clk, hs, vs, blank_n, sync_n, r, g, b;
   logic f_clk, f_hs, f_vs, f_blank_n, f_sync_n, f_r, f_g, f_b;

   pixel_fb_scanout #(
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus),
      .vga_clk_o(vga_clk), .vga_hs_o(hs), .vga_vs_o(vs), .vga_blank_n_o(blank_n),
      .vga_sync_n_o(sync_n), .vga_r_o(r), .vga_g_o(g), .vga_b_o(b)
   );

   pixel_fb_scanout dut_full (
      .clk(clk), .resetn(resetn), .bus(bus_full),
      .vga_clk_o(f_clk), .vga_hs_o(f_hs), .vga_vs_o(f_vs), .vga_blank_n_o(f_blank_n),
      .vga_sync_n_o(f_sync_n), .vga_r_o(f_r), .vga_g_o(f_g), .vga_b_o(f_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   logic [2:0] exp_view [VROWS*VCOLS];
   logic [2:0] cap_rgb  [HT*VT];
   logic       cap_hs   [HT*VT];
   logic       cap_vs   [HT*VT];
   logic       cap_bn   [HT*VT];

   function automatic logic [2:0] px(input int h, input int v);
      return cap_rgb[v*HT + h];
   endfunction

   function automatic logic [2:0] peek(input int a);
      return dut.mem_q[a];
   endfunction

   function automatic logic sel_sig(input int which);
      case (which)
         0:       return f_hs;
         1:       return hs;
         2:       return vs;
         default: return !bus.frame_start;
      endcase
   endfunction

   task automatic set_view(input logic [2:0] c);
      for (int i = 0; i < VROWS*VCOLS; i++) exp_view[i] = c;
   endtask

   task automatic wait_fs();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2*FRAME_CLK + 10; i++) begin
         @(negedge clk);
         if (bus.frame_start) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("frame_start_seen", 32'(ok), 32'd1);
   endtask

   // Called right at the frame_start sample; pixel n sits on the pins 3+2n negedges later.
   task automatic capture_frame();
      repeat (3) @(negedge clk);
      for (int n = 0; n < HT*VT; n++) begin
         cap_rgb[n] = {r, g, b};
         cap_hs[n]  = hs;
         cap_vs[n]  = vs;
         cap_bn[n]  = blank_n;
         if (n != HT*VT - 1) repeat (2) @(negedge clk);
      end
   endtask

   task automatic check_frame(input string tag, input bit with_sync);
      int bad_rgb, bad_sync, n;
      bit vis;
      logic [2:0] e;
      bad_rgb = 0;
      bad_sync = 0;
      for (int v = 0; v < VT; v++) begin
         for (int h = 0; h < HT; h++) begin
            n   = v*HT + h;
            vis = (h < HV) && (v < VV);
            e   = vis ? exp_view[(v/4)*VCOLS + h/4] : 3'b000;
            if (cap_rgb[n] !== e) bad_rgb++;
            if (cap_bn[n] !== vis) bad_sync++;
            if (cap_hs[n] !== !(h >= HV+HF && h < HV+HF+HS)) bad_sync++;
            if (cap_vs[n] !== !(v >= VV+VF && v < VV+VF+VS)) bad_sync++;
         end
      end
      check_eq({tag, "_rgb_bad_px"}, 32'(bad_rgb), 32'd0);
      if (with_sync) check_eq({tag, "_sync_bad_px"}, 32'(bad_sync), 32'd0);
   endtask

   task automatic measure(input int which, input int bound, output int low, output int period);
      int t;
      logic prev, cur;
      t = 0;
      @(negedge clk);
      prev = sel_sig(which);
      cur  = prev;
      while (t < bound) begin
         @(negedge clk);
         t++;
         cur = sel_sig(which);
         if (prev && !cur) break;
         prev = cur;
      end
      prev   = cur;
      period = 1;
      low    = 1;
      while (t < bound) begin
         @(negedge clk);
         t++;
         cur = sel_sig(which);
         if (prev && !cur) break;
         period++;
         if (!cur) low++;
         prev = cur;
      end
      if (t >= bound) begin
         low = 0;
         period = 0;
      end
   endtask

   task automatic plot_px(input int x, input int y, input logic [2:0] c);
      @(negedge clk);
      bus.x = 8'(x);
      bus.y = 7'(y);
      bus.colour = c;
      bus.plot = 1'b1;
      @(negedge clk);
      bus.plot = 1'b0;
   endtask

   // Returns the number of clk samples with clear_busy high; abort_at>0 pulls resetn there.
   task automatic run_clear(input int abort_at, output int busy_clks);
      @(negedge clk);
      bus.clear_req = 1'b1;
      @(negedge clk);
      bus.clear_req = 1'b0;
      busy_clks = 0;
      for (int i = 0; i < 30000; i++) begin
         if (!bus.clear_busy) break;
         busy_clks++;
         bus.x = 8'd5;
         bus.y = 7'd0;
         bus.colour = 3'b111;
         bus.plot = (busy_clks == 1000);
         if (busy_clks == abort_at) begin
            resetn = 1'b0;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.plot = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int low, period, busy;
      bus.plot = 0; bus.x = 0; bus.y = 0; bus.colour = 0; bus.clear_req = 0;
      bus_full.plot = 0; bus_full.x = 0; bus_full.y = 0; bus_full.colour = 0;
      bus_full.clear_req = 0;

      // Reset state
      repeat (10) @(negedge clk);
      check_eq("rst_vga_clk", 32'(vga_clk), 32'd0);
      check_eq("rst_hs", 32'(hs), 32'd1);
      check_eq("rst_vs", 32'(vs), 32'd1);
      check_eq("rst_blank_n", 32'(blank_n), 32'd0);
      check_eq("rst_rgb", 32'({r, g, b}), 32'd0);
      check_eq("rst_sync_n", 32'(sync_n), 32'd0);
      check_eq("rst_clear_busy", 32'(bus.clear_busy), 32'd0);
      check_eq("rst_frame_start", 32'(bus.frame_start), 32'd0);
      check_eq("rst_full_pins", 32'({f_clk, f_hs, f_vs, f_blank_n, f_sync_n, f_r, f_g, f_b}),
               32'b01100000);
      check_eq("rst_full_bus", 32'({bus_full.clear_busy, bus_full.frame_start}), 32'd0);
      resetn = 1'b1;

      // Sync timing: full-size horizontal, shrunken vertical and frame marker
      measure(0, 4000, low, period);
      check_eq("full_hs_period", 32'(period), 32'd1600);
      check_eq("full_hs_low", 32'(low), 32'd192);
      measure(1, 400, low, period);
      check_eq("hs_period", 32'(period), 32'd80);
      check_eq("hs_low", 32'(low), 32'd8);
      measure(2, 3*FRAME_CLK, low, period);
      check_eq("vs_period", 32'(period), 32'd960);
      check_eq("vs_low", 32'(low), 32'd160);
      measure(3, 3*FRAME_CLK, low, period);
      check_eq("fs_period", 32'(period), 32'd960);
      check_eq("fs_width", 32'(low), 32'd1);

      // Fill with green, then clear
      @(negedge clk);
      bus.plot = 1'b1;
      bus.colour = 3'b010;
      for (int yy = 0; yy < 120; yy++) begin
         for (int xx = 0; xx < 160; xx++) begin
            bus.x = 8'(xx);
            bus.y = 7'(yy);
            @(negedge clk);
         end
      end
      bus.plot = 1'b0;
      set_view(3'b010);
      wait_fs();
      capture_frame();
      check_frame("fill", 1'b1);
      check_eq("fill_corner", 32'(peek(19199)), 32'd2);

      run_clear(0, busy);
      check_eq("clear_busy_clks", 32'(busy), 32'd19200);
      set_view(3'b000);
      wait_fs();
      capture_frame();
      check_frame("cleared", 1'b1);
      check_eq("cleared_corner", 32'(peek(19199)), 32'd0);
      check_eq("cleared_mid", 32'(peek(9000)), 32'd0);

      // Single plot at the origin
      plot_px(0, 0, 3'b100);
      exp_view[0] = 3'b100;
      wait_fs();
      capture_frame();
      check_eq("origin_px00", 32'(px(0, 0)), 32'd4);
      check_eq("origin_px33", 32'(px(3, 3)), 32'd4);
      check_eq("origin_px40", 32'(px(4, 0)), 32'd0);
      check_eq("origin_px04", 32'(px(0, 4)), 32'd0);
      check_frame("origin", 1'b0);

      // Corner write and out-of-range drops
      plot_px(159, 119, 3'b111);
      plot_px(160, 5, 3'b111);
      plot_px(3, 120, 3'b111);
      plot_px(160, 0, 3'b111);
      check_eq("corner_white", 32'(peek(19199)), 32'd7);
      check_eq("xoor_no_wrap", 32'(peek(960)), 32'd0);
      wait_fs();
      capture_frame();
      check_frame("oor", 1'b0);

      // Write the address being read in that same clk
      wait_fs();
      fork
         capture_frame();
         begin
            bus.x = 8'd0;
            bus.y = 7'd0;
            bus.colour = 3'b011;
            bus.plot = 1'b1;
            @(negedge clk);
            bus.plot = 1'b0;
         end
      join
      check_eq("rw_same_old", 32'(px(0, 0)), 32'd4);
      check_eq("rw_same_new_h1", 32'(px(1, 0)), 32'd3);
      check_eq("rw_same_new_v1", 32'(px(0, 1)), 32'd3);
      exp_view[0] = 3'b011;
      wait_fs();
      capture_frame();
      check_frame("rw_next", 1'b0);

      // Reset in the middle of a clear sweep
      plot_px(100, 0, 3'b011);
      plot_px(0, 25, 3'b011);
      plot_px(80, 37, 3'b011);
      plot_px(159, 119, 3'b011);
      run_clear(5000, busy);
      check_eq("abort_busy_clks", 32'(busy), 32'd5000);
      check_eq("abort_clear_busy", 32'(bus.clear_busy), 32'd0);
      check_eq("abort_hs_vs", 32'({hs, vs}), 32'd3);
      check_eq("abort_blank_n", 32'(blank_n), 32'd0);
      resetn = 1'b1;
      check_eq("abort_addr100", 32'(peek(100)), 32'd0);
      check_eq("abort_addr4000", 32'(peek(4000)), 32'd0);
      check_eq("abort_addr6000", 32'(peek(6000)), 32'd3);
      check_eq("abort_addr19199", 32'(peek(19199)), 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
